// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: request size encodings,
// FSM state encoding, lane geometry and the alignment-error rule.
package mem_pkg;

    localparam int LANE_W = 8;
    localparam int DATA_W = 32;
    localparam int HALF_W = 2 * LANE_W;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // A half must sit on an even byte, a word on a word boundary, and the
    // reserved size code is never legal.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response channel plus the DRAM port of the memory access unit.
// The unit connects through the slave modport; the CPU/DRAM side uses master.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_error;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the memory access unit. Extracts and
// extends the addressed byte/half of a DRAM word for loads, and merges
// right-justified store data into that word for stores. Reserved size is
// handled as a word, and a half only looks at offset bit 1.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] memWord_i,
    input  logic [DATA_W-1:0] storeData_i,
    output logic [DATA_W-1:0] loadData_o,
    output logic [DATA_W-1:0] mergedWord_o
);

    logic [LANE_W-1:0] byteLane;
    logic [HALF_W-1:0] halfLane;
    logic [4:0]        byteBase;
    logic [4:0]        halfBase;

    assign byteBase = {offset_i, 3'b000};
    assign halfBase = {offset_i[1], 4'b0000};
    assign byteLane = memWord_i[byteBase +: LANE_W];
    assign halfLane = memWord_i[halfBase +: HALF_W];

    // Load path: pick the addressed lane(s) and sign- or zero-extend them.
    always_comb begin
        loadData_o = memWord_i;
        case (size_i)
            SZ_BYTE: loadData_o = {{(DATA_W-LANE_W){~unsigned_i & byteLane[LANE_W-1]}}, byteLane};
            SZ_HALF: loadData_o = {{(DATA_W-HALF_W){~unsigned_i & halfLane[HALF_W-1]}}, halfLane};
            default: loadData_o = memWord_i;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the fetched word.
    always_comb begin
        mergedWord_o = memWord_i;
        case (size_i)
            SZ_BYTE: mergedWord_o[byteBase +: LANE_W] = storeData_i[LANE_W-1:0];
            SZ_HALF: mergedWord_o[halfBase +: HALF_W] = storeData_i[HALF_W-1:0];
            default: mergedWord_o = storeData_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed DRAM. Accepts one request at a
// time, reads the target word, and either returns the extended load data or
// writes back a merged word (read-modify-write for every store size).
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned / reserved-size
// requests are rejected with resp_error and never touch the DRAM).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_e                  state_q, state_d;
    logic                    write_q, write_d;
    logic [1:0]              size_q, size_d;
    logic                    isUnsigned_q, isUnsigned_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   memWdata_q, memWdata_d;
    logic [DATA_WIDTH-1:0]   respRdata_q, respRdata_d;
    logic                    respError_q, respError_d;

    logic                    reqErr;
    logic [DATA_WIDTH-1:0]   alignLoad;
    logic [DATA_WIDTH-1:0]   alignMerge;

`ifdef MEM_ALIGN_CHECK_EN
    assign reqErr = isMisaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign reqErr = 1'b0;
`endif

    mem_lane_align u_align (
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (isUnsigned_q),
        .memWord_i    (bus.mem_rdata),
        .storeData_i  (wdata_q),
        .loadData_o   (alignLoad),
        .mergedWord_o (alignMerge)
    );

    // State register; reset always lands in IDLE and drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update: latch in IDLE, read in ACCESS, commit in WRITE.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        isUnsigned_d = isUnsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        memWdata_d   = memWdata_q;
        respRdata_d  = respRdata_q;
        respError_d  = respError_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d      = bus.req_write;
                    size_d       = bus.req_size;
                    isUnsigned_d = bus.req_unsigned;
                    addr_d       = bus.req_addr;
                    wdata_d      = bus.req_wdata;
                    respRdata_d  = '0;
                    respError_d  = reqErr;
                    state_d      = reqErr ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (write_q) begin
                    memWdata_d  = alignMerge;
                    respRdata_d = '0;
                    state_d     = ST_WRITE;
                end else begin
                    respRdata_d = alignLoad;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields and response/write-data registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            isUnsigned_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            memWdata_q   <= '0;
            respRdata_q  <= '0;
            respError_q  <= 1'b0;
        end else begin
            write_q      <= write_d;
            size_q       <= size_d;
            isUnsigned_q <= isUnsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            memWdata_q   <= memWdata_d;
            respRdata_q  <= respRdata_d;
            respError_q  <= respError_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = respRdata_q;
    assign bus.resp_error = respError_q;
    assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata  = memWdata_q;
    assign bus.mem_we     = (state_q == ST_WRITE) && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A 64-word DRAM model sits on the
// memory port; a separate reference memory plus arithmetic load/store rules
// predict every response, latency and final memory word.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] dram   [64];
    logic [31:0] refMem [64];
    logic        preloadEn;
    logic [5:0]  preloadIdx;
    logic [31:0] preloadData;

    int checks = 0;
    int errors = 0;

    // DRAM model: combinational read, write on the rising edge, plus a bench-only preload port.
    always @(posedge clk) begin
        if (preloadEn) dram[preloadIdx] <= preloadData;
        else if (bus.mem_we) dram[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = dram[bus.mem_addr[7:2]];

    // Reference load rule: shift the addressed lane down, mask, then extend.
    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = int'(off) * 8;
            v = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = (off >= 2'd2) ? 16 : 0;
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Reference store rule: clear the target lanes with a mask and OR in the new data.
    function automatic logic [31:0] refStore(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh = int'(off) * 8;
            mask = 32'hFF << sh;
            return (word & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = (off >= 2'd2) ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (word & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    function automatic logic refIsErr(input logic [1:0] sz, input logic [1:0] off);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        preloadEn   = 1'b1;
        preloadIdx  = idx[5:0];
        preloadData = val;
        @(negedge clk);
        preloadEn   = 1'b0;
        refMem[idx] = val;
    endtask

    // Drives one request once the unit is ready and measures the response.
    task automatic doRequest(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rdata, output logic err, output int lat,
                             output int weCnt, output int waitCycles, output logic readyAtResp);
        waitCycles  = 0;
        rdata       = 32'h0;
        err         = 1'b0;
        readyAtResp = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat   = 0;
        weCnt = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) weCnt++;
            if (bus.resp_valid) begin
                rdata       = bus.resp_rdata;
                err         = bus.resp_error;
                readyAtResp = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
        checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_error: got %b expected 0", bus.resp_error); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_loads();
        logic [31:0] rd; logic er; int lat, we, wt; logic rr;
        logic [31:0] addrs [3] = '{32'h12, 32'h12, 32'h10};
        logic [1:0]  sizes [3] = '{2'd0, 2'd1, 2'd2};
        logic        unsF  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [3] = '{32'hFFFFFF99, 32'h00008899, 32'h8899AABB};
        preload(4, 32'h8899AABB);
        for (int i = 0; i < 3; i++) begin
            doRequest(1'b0, sizes[i], unsF[i], addrs[i], 32'h0, rd, er, lat, we, wt, rr);
            checks++; if (rd !== exps[i]) begin errors++; $display("[TB] FAIL load_data[%0d]: got %h expected %h", i, rd, exps[i]); end
            checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL load_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL load_error[%0d]: got %b expected 0", i, er); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er; int lat, we, wt; logic rr;
        preload(8, 32'h11223344);
        doRequest(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000EE, rd, er, lat, we, wt, rr);
        checks++; if (dram[8] !== 32'h1122EE44) begin errors++; $display("[TB] FAIL store_byte_mem: got %h expected 1122ee44", dram[8]); end
        checks++; if (we !== 1) begin errors++; $display("[TB] FAIL store_byte_we_cycles: got %0d expected 1", we); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL store_byte_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL store_byte_rdata: got %h expected 0", rd); end
        preload(8, 32'h11223344);
        doRequest(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, rd, er, lat, we, wt, rr);
        doRequest(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, we, wt, rr);
        checks++; if (rd !== 32'hBEEF3344) begin errors++; $display("[TB] FAIL store_half_readback: got %h expected beef3344", rd); end
        refMem[8] = 32'hBEEF3344;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, wd, addr, expRd; logic er, wr, uns, rr, expErr; logic [1:0] sz;
        int lat, we, wt, idx, expLat;
        for (int i = 0; i < 6; i++) begin
            wr = (i % 2) == 1;
            sz = 2'(i % 3);
            uns = 1'b0;
            addr = 32'($urandom_range(0, 63)) << 2;
            wd = $urandom();
            idx = int'(addr[7:2]);
            expErr = refIsErr(sz, addr[1:0]);
            expRd = (wr || expErr) ? 32'h0 : refLoad(refMem[idx], addr[1:0], sz, uns);
            expLat = expErr ? 1 : (wr ? 3 : 2);
            if (wr && !expErr) refMem[idx] = refStore(refMem[idx], addr[1:0], sz, wd);
            doRequest(wr, sz, uns, addr, wd, rd, er, lat, we, wt, rr);
            if (i > 0) begin
                checks++; if (wt !== 0) begin errors++; $display("[TB] FAIL b2b_wait[%0d]: got %0d expected 0", i, wt); end
            end
            checks++; if (rr !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_resp[%0d]: got %b expected 0", i, rr); end
            checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, expLat); end
            checks++; if (rd !== expRd) begin errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", i, rd, expRd); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat, we, wt; logic rr;
        preload(8, 32'h11223344);
        doRequest(1'b1, 2'd2, 1'b0, 32'h23, 32'hCAFEF00D, rd, er, lat, we, wt, rr);
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_error: got %b expected 1", er); end
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL misaligned_latency: got %0d expected 1", lat); end
        checks++; if (we !== 0) begin errors++; $display("[TB] FAIL misaligned_we_cycles: got %0d expected 0", we); end
        checks++; if (dram[8] !== 32'h11223344) begin errors++; $display("[TB] FAIL misaligned_mem: got %h expected 11223344", dram[8]); end
`else
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL misaligned_error: got %b expected 0", er); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL misaligned_latency: got %0d expected 3", lat); end
        checks++; if (we !== 1) begin errors++; $display("[TB] FAIL misaligned_we_cycles: got %0d expected 1", we); end
        checks++; if (dram[8] !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL misaligned_mem: got %h expected cafef00d", dram[8]); end
        refMem[8] = 32'hCAFEF00D;
`endif
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL misaligned_rdata: got %h expected 0", rd); end
    endtask

    task automatic test_random(input int n);
        logic [31:0] rd, wd, addr, expRd; logic er, wr, uns, rr, expErr; logic [1:0] sz, off;
        int lat, we, wt, idx, expLat, expWe;
        for (int i = 0; i < n; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 255));
            wd   = $urandom();
            idx  = int'(addr[7:2]);
            off  = addr[1:0];
            expErr = refIsErr(sz, off);
            expRd  = (wr || expErr) ? 32'h0 : refLoad(refMem[idx], off, sz, uns);
            expLat = expErr ? 1 : (wr ? 3 : 2);
            expWe  = (wr && !expErr) ? 1 : 0;
            if (wr && !expErr) refMem[idx] = refStore(refMem[idx], off, sz, wd);
            doRequest(wr, sz, uns, addr, wd, rd, er, lat, we, wt, rr);
            checks++; if (rd !== expRd) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i, rd, expRd); end
            checks++; if (er !== expErr) begin errors++; $display("[TB] FAIL rand_error[%0d]: got %b expected %b", i, er, expErr); end
            checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, expLat); end
            checks++; if (we !== expWe) begin errors++; $display("[TB] FAIL rand_we_cycles[%0d]: got %0d expected %0d", i, we, expWe); end
            if (wr) begin
                checks++; if (dram[idx] !== refMem[idx]) begin errors++; $display("[TB] FAIL rand_mem[%0d]: got %h expected %h", i, dram[idx], refMem[idx]); end
            end
        end
    endtask

    task automatic test_reset_in_write();
        int waitCnt, respSeen;
        logic sawWrite;
        preload(12, 32'h5A5A5A5A);
        @(negedge clk);
        bus.req_write    = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h31;
        bus.req_wdata    = 32'h00000077;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        waitCnt  = 0;
        sawWrite = 1'b0;
        while (!sawWrite && waitCnt < 6) begin
            @(negedge clk);
            waitCnt++;
            sawWrite = bus.mem_we;
        end
        checks++; if (sawWrite !== 1'b1) begin errors++; $display("[TB] FAIL rstw_reached_write: got %b expected 1", sawWrite); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rstw_we_masked: got %b expected 0", bus.mem_we); end
        @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstw_req_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstw_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstw_resp_rdata: got %h expected 0", bus.resp_rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstw_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rstw_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rstw_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (dram[12] !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL rstw_mem_unchanged: got %h expected 5a5a5a5a", dram[12]); end
        @(negedge clk);
        rst = 1'b0;
        respSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid) respSeen++;
        end
        checks++; if (respSeen !== 0) begin errors++; $display("[TB] FAIL rstw_no_response: got %0d expected 0", respSeen); end
    endtask

    initial begin
        rst              = 1'b1;
        preloadEn        = 1'b0;
        preloadIdx       = 6'd0;
        preloadData      = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 64; i++) preload(i, $urandom());
        $display("[TB] memory preloaded, starting tests");
        test_reset();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misaligned();
        test_random(60);
        test_reset_in_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
